// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake,
// and holds one instruction in the IR for the decoder. Wrong-path fetches are drained.
//
//  state | meaning
//  FETCH | request outstanding at imem_addr
//  HOLD  | IR valid, waiting for the decoder to take it
//  DRAIN | wrong-path request outstanding, returned data is discarded
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        redirect,
    input  logic [31:0] redirect_target
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] addr_nxt;
    logic [31:0] ir_nxt;
    logic [31:0] pc_out_nxt;
    logic        ir_valid_nxt;
    logic [31:0] tgt;

    assign tgt = redirect_target & ~32'h0000_0003;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            imem_addr <= RESET_PC;
            ir        <= 32'h0;
            ir_valid  <= 1'b0;
            pc_out    <= 32'h0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            imem_addr <= addr_nxt;
            ir        <= ir_nxt;
            ir_valid  <= ir_valid_nxt;
            pc_out    <= pc_out_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        addr_nxt     = imem_addr;
        ir_nxt       = ir;
        ir_valid_nxt = ir_valid;
        pc_out_nxt   = pc_out;
        case (state)
            S_FETCH: begin
                if (redirect) begin
                    pc_nxt = tgt;
                    // The request address may only move once the current transfer completes.
                    if (imem_ack) addr_nxt = tgt;
                    else          state_nxt = S_DRAIN;
                end else if (imem_ack) begin
                    ir_nxt       = imem_rdata;
                    pc_out_nxt   = imem_addr;
                    ir_valid_nxt = 1'b1;
                    pc_nxt       = imem_addr + 32'd4;
                    state_nxt    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_nxt       = tgt;
                    ir_valid_nxt = 1'b0;
                    addr_nxt     = tgt;
                    state_nxt    = S_FETCH;
                end else if (ir_ready) begin
                    ir_valid_nxt = 1'b0;
                    addr_nxt     = pc;
                    state_nxt    = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (redirect) pc_nxt = tgt;
                if (imem_ack) begin
                    addr_nxt  = redirect ? tgt : pc;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                ir_valid_nxt = 1'b0;
                state_nxt    = S_FETCH;
            end
        endcase
    end

    assign imem_req = (state == S_FETCH) || (state == S_DRAIN);
    assign op       = ir[31:26];
    assign funct    = ir[5:0];
    assign pc_plus4 = pc_out + 32'd4;

endmodule
